// File: rtl/com_bus_rr_arbiter_pkg.sv
// com_bus_arb_pkg: shared types and helpers for the coherence bus arbiter.
//   arb_state_t  - arbiter FSM states
//   gnt_class_t  - owner class reported on Gnt_class
//   clog2_min1   - index width that never collapses to zero bits
package com_bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, OWN, TURN} arb_state_t;

    typedef enum logic [1:0] {NONE, PROC, SNOOP, MEM} gnt_class_t;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/com_bus_rr_arbiter_if.sv
// com_bus_rr_arbiter_if: request/grant/status bundle of the coherence bus arbiter.
//   Com_Bus_Req_proc/snoop, Mem_snoop_req  - level requests from cores, snoopers, memory
//   Com_Bus_Gnt_proc/snoop, Mem_snoop_gnt  - registered one-hot grants
//   Bus_busy, Gnt_class, Gnt_idx, Preempt  - owner status
//   modport master: requester side; modport slave: arbiter side
interface com_bus_rr_arbiter_if
    import com_bus_arb_pkg::*;
#(
    parameter int NUM_PROC  = 8,
    parameter int NUM_SNOOP = 4
);
    localparam int IW = clog2_min1(NUM_PROC > NUM_SNOOP ? NUM_PROC : NUM_SNOOP);

    logic [NUM_PROC-1:0]  Com_Bus_Req_proc;
    logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop;
    logic                 Mem_snoop_req;
    logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc;
    logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop;
    logic                 Mem_snoop_gnt;
    logic                 Bus_busy;
    logic [1:0]           Gnt_class;
    logic [IW-1:0]        Gnt_idx;
    logic                 Preempt;

    modport master (
        output Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
        input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt,
        input  Bus_busy, Gnt_class, Gnt_idx, Preempt
    );

    modport slave (
        input  Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
        output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt,
        output Bus_busy, Gnt_class, Gnt_idx, Preempt
    );

endinterface

// File: rtl/com_bus_rr_arbiter_rr_pick.sv
// rr_pick: round-robin winner selection for one requester class.
//   clk, rst  - clock, asynchronous active-high reset (pointer to N-1)
//   req       - level requests of the class
//   advance   - load the pointer with adv_idx (last winner of the class)
//   any       - at least one request is high
//   winner    - one-hot winner, searched from pointer+1 with wrap
//   win_idx   - binary index of winner
module rr_pick
    import com_bus_arb_pkg::*;
#(
    parameter int  N  = 4,
    localparam int IW = clog2_min1(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [IW-1:0] adv_idx,
    output logic          any,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] win_idx
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] k;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            ptr <= IW'(N - 1);
        else if (advance)
            ptr <= adv_idx;

    // Scan from farthest to nearest so the slot closest after ptr overwrites the rest.
    always_comb begin
        win_idx = '0;
        k = '0;
        for (int i = N; i >= 1; i--) begin
            k = IW'((int'(ptr) + i) % N);
            if (req[k])
                win_idx = k;
        end
    end

    assign any    = |req;
    assign winner = any ? N'(1) << win_idx : '0;

endmodule

// File: rtl/com_bus_rr_arbiter.sv
// com_bus_rr_arbiter: round-robin owner arbiter for the shared coherence bus.
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - slave modport: proc/snoop/mem requests in, registered grants
//               and owner status (Bus_busy, Gnt_class, Gnt_idx, Preempt) out
// Priority snoop > mem > proc, round-robin inside snoop and proc classes.
// Processor owners lose the bus after MAX_HOLD cycles when anyone else waits.
// Every ownership is followed by one turnaround cycle with all grants low.
module com_bus_rr_arbiter
    import com_bus_arb_pkg::*;
#(
    parameter int NUM_PROC  = 8,
    parameter int NUM_SNOOP = 4,
    parameter int MAX_HOLD  = 64
) (
    input logic                 clk,
    input logic                 rst,
    com_bus_rr_arbiter_if.slave bus
);
    localparam int PW = clog2_min1(NUM_PROC);
    localparam int SW = clog2_min1(NUM_SNOOP);
    localparam int IW = clog2_min1(NUM_PROC > NUM_SNOOP ? NUM_PROC : NUM_SNOOP);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_t           state_q, state_n;
    gnt_class_t           cls_q, cls_n;
    logic [NUM_PROC-1:0]  gnt_proc_q, gnt_proc_n;
    logic [NUM_SNOOP-1:0] gnt_snoop_q, gnt_snoop_n;
    logic                 gnt_mem_q, gnt_mem_n;
    logic [IW-1:0]        idx_q, idx_n;
    logic [HW-1:0]        hold_q, hold_n, hold_inc;
    logic                 pre_q, pre_n;
    logic                 p_any, s_any;
    logic [NUM_PROC-1:0]  p_win;
    logic [NUM_SNOOP-1:0] s_win;
    logic [PW-1:0]        p_idx, adv_proc_idx;
    logic [SW-1:0]        s_idx;
    logic                 adv_proc, adv_snoop;
    logic                 own_req, others, preempt_hit;

    rr_pick #(.N(NUM_PROC)) u_proc_pick (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.Com_Bus_Req_proc),
        .advance (adv_proc),
        .adv_idx (adv_proc_idx),
        .any     (p_any),
        .winner  (p_win),
        .win_idx (p_idx)
    );

    rr_pick #(.N(NUM_SNOOP)) u_snoop_pick (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.Com_Bus_Req_snoop),
        .advance (adv_snoop),
        .adv_idx (s_idx),
        .any     (s_any),
        .winner  (s_win),
        .win_idx (s_idx)
    );

    // Grants are one-hot, so masking requests with them isolates the owner.
    assign own_req     = |{bus.Com_Bus_Req_proc & gnt_proc_q, bus.Com_Bus_Req_snoop & gnt_snoop_q, bus.Mem_snoop_req & gnt_mem_q};
    assign others      = |{bus.Com_Bus_Req_proc & ~gnt_proc_q, bus.Com_Bus_Req_snoop & ~gnt_snoop_q, bus.Mem_snoop_req & ~gnt_mem_q};
    assign hold_inc    = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
    assign preempt_hit = (cls_q == PROC) && (hold_inc == HW'(MAX_HOLD)) && others;

    always_comb begin
        state_n      = state_q;
        cls_n        = cls_q;
        gnt_proc_n   = gnt_proc_q;
        gnt_snoop_n  = gnt_snoop_q;
        gnt_mem_n    = gnt_mem_q;
        idx_n        = idx_q;
        hold_n       = hold_q;
        pre_n        = 1'b0;
        adv_proc     = 1'b0;
        adv_snoop    = 1'b0;
        adv_proc_idx = p_idx;
        unique case (state_q)
            IDLE: begin
                hold_n = '0;
                if (s_any) begin
                    gnt_snoop_n = s_win;
                    cls_n       = SNOOP;
                    idx_n       = IW'(s_idx);
                    adv_snoop   = 1'b1;
                    state_n     = OWN;
                end else if (bus.Mem_snoop_req) begin
                    gnt_mem_n = 1'b1;
                    cls_n     = MEM;
                    idx_n     = '0;
                    state_n   = OWN;
                end else if (p_any) begin
                    gnt_proc_n = p_win;
                    cls_n      = PROC;
                    idx_n      = IW'(p_idx);
                    adv_proc   = 1'b1;
                    state_n    = OWN;
                end
            end
            OWN: begin
                hold_n = hold_inc;
                if (!own_req || preempt_hit) begin
                    gnt_proc_n  = '0;
                    gnt_snoop_n = '0;
                    gnt_mem_n   = 1'b0;
                    cls_n       = NONE;
                    idx_n       = '0;
                    state_n     = TURN;
                    // Owner still requesting here means the hold limit revoked it;
                    // pin the proc pointer on it so the search resumes past it.
                    pre_n        = own_req;
                    adv_proc     = own_req;
                    adv_proc_idx = PW'(idx_q);
                end
            end
            TURN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= IDLE;
            cls_q       <= NONE;
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            gnt_mem_q   <= 1'b0;
            idx_q       <= '0;
            hold_q      <= '0;
            pre_q       <= 1'b0;
        end else begin
            state_q     <= state_n;
            cls_q       <= cls_n;
            gnt_proc_q  <= gnt_proc_n;
            gnt_snoop_q <= gnt_snoop_n;
            gnt_mem_q   <= gnt_mem_n;
            idx_q       <= idx_n;
            hold_q      <= hold_n;
            pre_q       <= pre_n;
        end

    assign bus.Com_Bus_Gnt_proc  = gnt_proc_q;
    assign bus.Com_Bus_Gnt_snoop = gnt_snoop_q;
    assign bus.Mem_snoop_gnt     = gnt_mem_q;
    assign bus.Bus_busy          = |{gnt_proc_q, gnt_snoop_q, gnt_mem_q};
    assign bus.Gnt_class         = cls_q;
    assign bus.Gnt_idx           = idx_q;
    assign bus.Preempt           = pre_q;

    assert property (@(posedge clk) disable iff (rst) $onehot0({gnt_proc_q, gnt_snoop_q, gnt_mem_q}));

endmodule

// File: tb/tb_com_bus_rr_arbiter.sv
// tb_com_bus_rr_arbiter: scoreboard bench for com_bus_rr_arbiter (8/4 with MAX_HOLD=4, and 3/1).
module tb_com_bus_rr_arbiter;
    import com_bus_arb_pkg::*;

    typedef struct {
        logic [7:0] gp;
        logic [3:0] gs;
        logic       gm;
        logic [1:0] cls;
        logic [2:0] idx;
        int         gap;
    } own_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    checks = 0;
    int    errors = 0;
    int    pre_a = 0;
    own_t  qa[$];
    own_t  qb[$];
    own_t  mon_a, mon_b;
    logic [12:0] cur_a, prev_a;
    logic [3:0]  cur_b, prev_b;
    int    gap_a = 0, len_a = 0, gap_b = 0;

    com_bus_rr_arbiter_if #(.NUM_PROC(8), .NUM_SNOOP(4)) ia ();
    com_bus_rr_arbiter_if #(.NUM_PROC(3), .NUM_SNOOP(1)) ib ();

    com_bus_rr_arbiter #(.NUM_PROC(8), .NUM_SNOOP(4), .MAX_HOLD(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    com_bus_rr_arbiter #(.NUM_PROC(3), .NUM_SNOOP(1), .MAX_HOLD(64)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
        end
    endtask

    function automatic own_t mk(input logic [7:0] gp, input logic [3:0] gs, input logic gm,
                                input logic [1:0] cls, input logic [2:0] idx, input int gap);
        own_t o;
        o.gp = gp;
        o.gs = gs;
        o.gm = gm;
        o.cls = cls;
        o.idx = idx;
        o.gap = gap;
        return o;
    endfunction

    task automatic cmp_own(input string tag, input own_t e, input own_t a, input int gap);
        chk({tag, ".gnt_proc"}, int'(a.gp), int'(e.gp));
        chk({tag, ".gnt_snoop"}, int'(a.gs), int'(e.gs));
        chk({tag, ".gnt_mem"}, int'(a.gm), int'(e.gm));
        chk({tag, ".class"}, int'(a.cls), int'(e.cls));
        chk({tag, ".idx"}, int'(a.idx), int'(e.idx));
        if (e.gap >= 0)
            chk({tag, ".gap"}, gap, e.gap);
    endtask

    task automatic wait_drain(input string nm, input bit on_b, input int target);
        int n;
        n = 0;
        while ((on_b ? qb.size() : qa.size()) > target && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({nm, ".drain"}, on_b ? qb.size() : qa.size(), target);
    endtask

    // Monitor A: every new ownership pops one expected record; Preempt pulses are timed.
    always @(negedge clk) begin
        cur_a = {ia.Com_Bus_Gnt_proc, ia.Com_Bus_Gnt_snoop, ia.Mem_snoop_gnt};
        if (rst) begin
            prev_a = '0;
            gap_a = 0;
        end else begin
            if (cur_a != '0 && cur_a != prev_a) begin
                mon_a.gp = ia.Com_Bus_Gnt_proc;
                mon_a.gs = ia.Com_Bus_Gnt_snoop;
                mon_a.gm = ia.Mem_snoop_gnt;
                mon_a.cls = ia.Gnt_class;
                mon_a.idx = ia.Gnt_idx;
                mon_a.gap = 0;
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a.unexpected_grant: got 'h%0h, expected no grant", cur_a);
                end else
                    cmp_own("a", qa.pop_front(), mon_a, gap_a);
                gap_a = 0;
                len_a = 1;
            end else if (cur_a != '0)
                len_a++;
            else
                gap_a++;
            if (ia.Preempt) begin
                pre_a++;
                chk("a.preempt_len", len_a, 4);
                chk("a.preempt_gnt", int'(cur_a), 0);
            end
            prev_a = cur_a;
        end
    end

    always @(negedge clk) begin
        cur_b = {ib.Com_Bus_Gnt_proc, ib.Mem_snoop_gnt};
        if (rst) begin
            prev_b = '0;
            gap_b = 0;
        end else begin
            if (cur_b != '0 && cur_b != prev_b) begin
                mon_b.gp = 8'(ib.Com_Bus_Gnt_proc);
                mon_b.gs = 4'(ib.Com_Bus_Gnt_snoop);
                mon_b.gm = ib.Mem_snoop_gnt;
                mon_b.cls = ib.Gnt_class;
                mon_b.idx = 3'(ib.Gnt_idx);
                mon_b.gap = 0;
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b.unexpected_grant: got 'h%0h, expected no grant", cur_b);
                end else
                    cmp_own("b", qb.pop_front(), mon_b, gap_b);
                gap_b = 0;
            end else if (cur_b == '0)
                gap_b++;
            prev_b = cur_b;
        end
    end

    initial begin
        ia.Com_Bus_Req_proc = '0;
        ia.Com_Bus_Req_snoop = '0;
        ia.Mem_snoop_req = 1'b0;
        ib.Com_Bus_Req_proc = '0;
        ib.Com_Bus_Req_snoop = '0;
        ib.Mem_snoop_req = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("rst.gnt_proc", int'(ia.Com_Bus_Gnt_proc), 0);
        chk("rst.gnt_snoop", int'(ia.Com_Bus_Gnt_snoop), 0);
        chk("rst.gnt_mem", int'(ia.Mem_snoop_gnt), 0);
        chk("rst.busy", int'(ia.Bus_busy), 0);
        chk("rst.class", int'(ia.Gnt_class), 0);
        chk("rst.idx", int'(ia.Gnt_idx), 0);
        chk("rst.preempt", int'(ia.Preempt), 0);
        chk("rst.b_busy", int'(ib.Bus_busy), 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        // Proc rotation 0 -> 2 -> 0 with turnaround gaps.
        qa.push_back(mk(8'h01, 4'h0, 1'b0, 2'd1, 3'd0, -1));
        ia.Com_Bus_Req_proc = 8'h05;
        @(posedge clk);
        #1;
        chk("a.latency", int'(ia.Com_Bus_Gnt_proc), 'h01);
        wait_drain("a.p0", 1'b0, 0);
        qa.push_back(mk(8'h04, 4'h0, 1'b0, 2'd1, 3'd2, 2));
        ia.Com_Bus_Req_proc = 8'h04;
        wait_drain("a.p2", 1'b0, 0);
        qa.push_back(mk(8'h01, 4'h0, 1'b0, 2'd1, 3'd0, 2));
        ia.Com_Bus_Req_proc = 8'h01;
        wait_drain("a.p0b", 1'b0, 0);
        ia.Com_Bus_Req_proc = '0;
        repeat (4) @(negedge clk);
        #1;
        // Class priority snoop > mem > proc.
        qa.push_back(mk(8'h00, 4'h2, 1'b0, 2'd2, 3'd1, -1));
        ia.Com_Bus_Req_proc = 8'h08;
        ia.Com_Bus_Req_snoop = 4'h2;
        ia.Mem_snoop_req = 1'b1;
        wait_drain("a.snoop", 1'b0, 0);
        qa.push_back(mk(8'h00, 4'h0, 1'b1, 2'd3, 3'd0, 2));
        ia.Com_Bus_Req_snoop = 4'h0;
        wait_drain("a.mem", 1'b0, 0);
        qa.push_back(mk(8'h08, 4'h0, 1'b0, 2'd1, 3'd3, 2));
        ia.Mem_snoop_req = 1'b0;
        wait_drain("a.p3", 1'b0, 0);
        ia.Com_Bus_Req_proc = '0;
        repeat (4) @(negedge clk);
        #1;
        // Hold-limit preemption of proc 1 by proc 6.
        qa.push_back(mk(8'h02, 4'h0, 1'b0, 2'd1, 3'd1, -1));
        ia.Com_Bus_Req_proc = 8'h02;
        wait_drain("a.p1", 1'b0, 0);
        @(negedge clk);
        #1;
        qa.push_back(mk(8'h40, 4'h0, 1'b0, 2'd1, 3'd6, 2));
        ia.Com_Bus_Req_proc = 8'h42;
        wait_drain("a.p6", 1'b0, 0);
        ia.Com_Bus_Req_proc = '0;
        repeat (4) @(negedge clk);
        #1;
        chk("a.preempt_count", pre_a, 1);
        // Snoop owner is never preempted.
        qa.push_back(mk(8'h00, 4'h1, 1'b0, 2'd2, 3'd0, -1));
        ia.Com_Bus_Req_snoop = 4'h1;
        ia.Com_Bus_Req_proc = 8'hFF;
        wait_drain("a.s0", 1'b0, 0);
        repeat (100) @(negedge clk);
        #1;
        chk("a.snoop_hold", int'(ia.Com_Bus_Gnt_snoop), 'h1);
        chk("a.snoop_no_preempt", pre_a, 1);
        qa.push_back(mk(8'h80, 4'h0, 1'b0, 2'd1, 3'd7, 2));
        ia.Com_Bus_Req_snoop = 4'h0;
        wait_drain("a.p7", 1'b0, 0);
        // Asynchronous reset in the middle of a proc ownership.
        #2 rst = 1'b1;
        #1;
        chk("a.async_gnt", int'(ia.Com_Bus_Gnt_proc), 0);
        chk("a.async_busy", int'(ia.Bus_busy), 0);
        chk("a.async_class", int'(ia.Gnt_class), 0);
        qa.push_back(mk(8'h01, 4'h0, 1'b0, 2'd1, 3'd0, -1));
        @(negedge clk);
        #1 rst = 1'b0;
        wait_drain("a.post_rst", 1'b0, 0);
        ia.Com_Bus_Req_proc = '0;
        repeat (4) @(negedge clk);
        #1;
        // Three-core build: owners blip their request, order 0,1,2,0.
        qb.push_back(mk(8'h01, 4'h0, 1'b0, 2'd1, 3'd0, -1));
        qb.push_back(mk(8'h02, 4'h0, 1'b0, 2'd1, 3'd1, 2));
        qb.push_back(mk(8'h04, 4'h0, 1'b0, 2'd1, 3'd2, 2));
        qb.push_back(mk(8'h01, 4'h0, 1'b0, 2'd1, 3'd0, 2));
        ib.Com_Bus_Req_proc = 3'b111;
        for (int i = 3; i >= 0; i--) begin
            wait_drain("b.rr", 1'b1, i);
            ib.Com_Bus_Req_proc = 3'b111 & ~ib.Com_Bus_Gnt_proc;
            @(negedge clk);
            #1;
            ib.Com_Bus_Req_proc = 3'b111;
        end
        ib.Com_Bus_Req_proc = '0;
        repeat (6) @(negedge clk);
        #1;
        chk("a.preempt_total", pre_a, 1);
        chk("a.queue_empty", qa.size(), 0);
        chk("b.queue_empty", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
